// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline types: default IF/ID widths, the NOP encoding and the IF/ID beat layout.
package mips_pipe_pkg;

  localparam int IF_ID_INSTR_W = 32;
  localparam int IF_ID_PC_W    = 32;

  // sll $0,$0,0 encodes as all zeros
  localparam logic [31:0] IF_ID_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [IF_ID_INSTR_W-1:0] instr;
    logic [IF_ID_PC_W-1:0]    pc4;
  } if_id_beat_t;

  // Occupancy of the (main, skid) slot pair
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_ONE     = 2'b01,
    ST_FULL    = 2'b10,
    ST_ILLEGAL = 2'b11
  } if_id_state_t;

endpackage

// File: rtl/pipe_slot.sv
// One valid+payload register; clear beats load, reset beats both.
// Cleared/reset payload takes RST_DAT so an empty slot presents a known value.
module pipe_slot #(
  parameter int           W       = 64,
  parameter logic [W-1:0] RST_DAT = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_dat,
  output logic         o_vld,
  output logic [W-1:0] o_dat
);

  logic         r_vld;
  logic [W-1:0] r_dat;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vld <= 1'b0;
      r_dat <= RST_DAT;
    end else if (i_clr) begin
      r_vld <= 1'b0;
      r_dat <= RST_DAT;
    end else if (i_load) begin
      r_vld <= 1'b1;
      r_dat <= i_dat;
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with one-entry skid buffer, flush-to-bubble and 1-cycle latency.
// Optional stall/flush statistics counters are built when IF_ID_STATS_EN is defined.
module if_id_skid_reg
  import mips_pipe_pkg::*;
#(
  parameter int                 INSTR_W   = IF_ID_INSTR_W,
  parameter int                 PC_W      = IF_ID_PC_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(IF_ID_NOP),
  parameter int                 STAT_W    = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc4,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc4
`ifdef IF_ID_STATS_EN
  ,
  output logic [STAT_W-1:0]  stall_cnt,
  output logic [STAT_W-1:0]  flush_cnt
`endif
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc4;
  } beat_t;

  localparam int    BEAT_W   = $bits(beat_t);
  localparam beat_t RST_BEAT = '{instr: NOP_INSTR, pc4: '0};

  beat_t        w_in_dat;
  beat_t        w_main_dat;
  beat_t        w_skid_dat;
  beat_t        w_main_din;
  logic         w_main_vld;
  logic         w_skid_vld;
  logic         w_accept;
  logic         w_xfer;
  logic         w_main_load;
  logic         w_main_clr;
  logic         w_main_from_skid;
  logic         w_skid_load;
  logic         w_skid_clr;
  if_id_state_t w_state;

  assign w_in_dat = '{instr: in_instr, pc4: in_pc4};
  assign w_accept = in_valid && in_ready;
  assign w_xfer   = out_valid && out_ready;

  // State register: the two slot valid bits are the FSM state
  pipe_slot #(.W(BEAT_W), .RST_DAT(RST_BEAT)) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_main_clr),
    .i_load  (w_main_load),
    .i_dat   (w_main_din),
    .o_vld   (w_main_vld),
    .o_dat   (w_main_dat)
  );

  pipe_slot #(.W(BEAT_W), .RST_DAT(RST_BEAT)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_skid_clr),
    .i_load  (w_skid_load),
    .i_dat   (w_in_dat),
    .o_vld   (w_skid_vld),
    .o_dat   (w_skid_dat)
  );

  always_comb begin
    case ({w_main_vld, w_skid_vld})
      2'b00:   w_state = ST_EMPTY;
      2'b10:   w_state = ST_ONE;
      2'b11:   w_state = ST_FULL;
      default: w_state = ST_ILLEGAL;
    endcase
  end

  // Next-state: translate the occupancy and handshakes into slot load/clear strobes
  always_comb begin
    w_main_load      = 1'b0;
    w_main_clr       = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clr       = 1'b0;
    if (flush) begin
      w_main_clr = 1'b1;
      w_skid_clr = 1'b1;
    end else begin
      case (w_state)
        ST_EMPTY: begin
          w_main_load = w_accept;
        end
        ST_ONE: begin
          if (w_xfer) begin
            w_main_load = w_accept;
            w_main_clr  = !w_accept;
          end else begin
            w_skid_load = w_accept;
          end
        end
        ST_FULL: begin
          if (w_xfer) begin
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_clr       = 1'b1;
          end
        end
        default: begin
          w_main_clr = 1'b1;
          w_skid_clr = 1'b1;
        end
      endcase
    end
  end

  assign w_main_din = w_main_from_skid ? w_skid_dat : w_in_dat;

  // Outputs come straight from flops; a cleared main slot already holds NOP/0
  always_comb begin
    in_ready  = !w_skid_vld;
    out_valid = w_main_vld;
    out_instr = w_main_dat.instr;
    out_pc4   = w_main_dat.pc4;
  end

  a_no_orphan_skid : assert property (@(posedge clk) disable iff (!reset_n)
                                      w_state != ST_ILLEGAL);

`ifdef IF_ID_STATS_EN
  logic [STAT_W-1:0] r_stall_cnt;
  logic [STAT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + STAT_W'(1);
      end
      if (flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + STAT_W'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed bench for if_id_skid_reg with a queue scoreboard of beats held by the register.
// With IF_ID_STATS_EN defined, a second STAT_W=2 instance exercises counter saturation.
module tb_if_id_skid_reg;
  import mips_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc4;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc4;
`ifdef IF_ID_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic        d2_in_ready;
  logic        d2_out_valid;
  logic [31:0] d2_out_instr;
  logic [31:0] d2_out_pc4;
  logic [1:0]  d2_stall_cnt;
  logic [1:0]  d2_flush_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;
  if_id_beat_t q[$];

  always #5 clk = ~clk;

  if_id_skid_reg dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc4    (in_pc4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc4   (out_pc4)
`ifdef IF_ID_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

`ifdef IF_ID_STATS_EN
  if_id_skid_reg #(.STAT_W(2)) dut2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (d2_in_ready),
    .in_instr  (in_instr),
    .in_pc4    (in_pc4),
    .out_valid (d2_out_valid),
    .out_ready (out_ready),
    .out_instr (d2_out_instr),
    .out_pc4   (d2_out_pc4),
    .stall_cnt (d2_stall_cnt),
    .flush_cnt (d2_flush_cnt)
  );
`endif

  task automatic chk1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc4);
    in_valid = v;
    in_instr = instr;
    in_pc4   = pc4;
  endtask

  // One clock: score the pre-edge handshakes, then check occupancy after the edge
  task automatic tick();
    if_id_beat_t e;
    logic        acc;
    logic        xfer;
    #1;
    acc  = in_valid && in_ready && reset_n && !flush;
    xfer = out_valid && out_ready && reset_n;
    if (xfer && q.size() != 0) begin
      e = q.pop_front();
      chk32("xfer_instr", out_instr, e.instr);
      chk32("xfer_pc4", out_pc4, e.pc4);
    end
    if (!reset_n || flush) q.delete();
    else if (acc) q.push_back('{instr: in_instr, pc4: in_pc4});
    @(posedge clk);
    @(negedge clk);
    chk1("out_valid", out_valid, q.size() != 0);
    chk1("in_ready", in_ready, q.size() < 2);
    if (q.size() == 0) begin
      chk32("idle_instr", out_instr, IF_ID_NOP);
      chk32("idle_pc4", out_pc4, 32'h0);
    end else begin
      chk32("head_instr", out_instr, q[0].instr);
      chk32("head_pc4", out_pc4, q[0].pc4);
    end
`ifdef IF_ID_STATS_EN
    chk32("dut2_instr", d2_out_instr, out_instr);
    chk32("dut2_pc4", d2_out_pc4, out_pc4);
    chk1("dut2_valid", d2_out_valid, out_valid);
    chk1("dut2_ready", d2_in_ready, in_ready);
`endif
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'hDEAD0000, 32'h100);
    @(negedge clk);

    // Reset held two cycles with a beat offered
    tick();
    tick();
    chk1("rst_out_valid", out_valid, 1'b0);
    chk32("rst_out_instr", out_instr, 32'h0);
    chk32("rst_out_pc4", out_pc4, 32'h0);
    chk1("rst_in_ready", in_ready, 1'b1);

    // Streaming at full rate
    reset_n = 1'b1;
    drive(1'b1, 32'h8C010004, 32'h4);
    tick();
    chk32("stream0", out_instr, 32'h8C010004);
    drive(1'b1, 32'h20220001, 32'h8);
    tick();
    chk32("stream1", out_instr, 32'h20220001);
    drive(1'b1, 32'h01095020, 32'hC);
    tick();
    chk32("stream2", out_instr, 32'h01095020);
    chk1("stream_in_ready", in_ready, 1'b1);
    drive(1'b0, 32'h0, 32'h0);
    tick();

    // Stall fills the skid; extra offer while full must be refused
    out_ready = 1'b0;
    drive(1'b1, 32'hAAAA0001, 32'h10);
    tick();
    drive(1'b1, 32'hBBBB0002, 32'h14);
    tick();
    chk1("skid_in_ready", in_ready, 1'b0);
    drive(1'b1, 32'hDDDD0004, 32'h18);
    tick();
    chk32("skid_hold", out_instr, 32'hAAAA0001);
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    tick();
    chk32("skid_second", out_instr, 32'hBBBB0002);
    chk1("skid_ready_back", in_ready, 1'b1);
    tick();

    // Flush from FULL with a beat offered
    out_ready = 1'b0;
    drive(1'b1, 32'h11110001, 32'h20);
    tick();
    drive(1'b1, 32'h22220002, 32'h24);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'hCCCC0003, 32'h1C);
    tick();
    flush = 1'b0;
    chk1("flush_valid", out_valid, 1'b0);
    chk32("flush_instr", out_instr, IF_ID_NOP);
    chk1("flush_in_ready", in_ready, 1'b1);
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    repeat (3) tick();

    // Reset together with flush while FULL
    out_ready = 1'b0;
    drive(1'b1, 32'h33330001, 32'h30);
    tick();
    drive(1'b1, 32'h33330002, 32'h34);
    tick();
    chk1("full_again", in_ready, 1'b0);
    reset_n = 1'b0;
    flush   = 1'b1;
    drive(1'b1, 32'h44440005, 32'h38);
    tick();
    chk1("mid_rst_valid", out_valid, 1'b0);
    chk32("mid_rst_instr", out_instr, 32'h0);
    chk32("mid_rst_pc4", out_pc4, 32'h0);
    chk1("mid_rst_in_ready", in_ready, 1'b1);
    reset_n = 1'b1;
    flush   = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    tick();

`ifdef IF_ID_STATS_EN
    chk32("stall_cnt_rst", 32'(stall_cnt), 32'd0);
    chk32("flush_cnt_rst", 32'(flush_cnt), 32'd0);
    out_ready = 1'b0;
    drive(1'b1, 32'h55550001, 32'h40);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    repeat (6) tick();
    chk32("stall_cnt", 32'(stall_cnt), 32'd6);
    chk32("stall_cnt_sat", 32'(d2_stall_cnt), 32'd3);
    out_ready = 1'b1;
    tick();
    flush = 1'b1;
    repeat (2) tick();
    flush = 1'b0;
    chk32("flush_cnt", 32'(flush_cnt), 32'd2);
    chk32("flush_cnt_w2", 32'(d2_flush_cnt), 32'd2);
    chk32("stall_cnt_after", 32'(stall_cnt), 32'd6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- Parametrised IF/ID pipeline register for the MIPS core, sitting between fetch (PC+4 and instruction memory) and decode.
- Adds over the previous IF/ID latch: clocked operation, per-beat valid bit, valid/ready handshake, a one-entry skid buffer for full throughput under downstream stall, a synchronous flush that injects a bubble, and configurable widths.
- Latency 1 cycle; sustained throughput 1 beat/cycle.

Parameters:
- INSTR_W, 32, instruction field width.
- PC_W, 32, PC+4 field width.
- NOP_INSTR, 32'h0000_0000, instruction value presented while out_valid=0 and after flush/reset.
- STAT_W, 16, statistics counter width (used only with IF_ID_STATS_EN).

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous clear: discard both held entries and any beat offered this cycle.
- in_valid  in  1  fetch presents a beat.
- in_ready  out  1  register can accept; registered, equals NOT skid_valid.
- in_instr  in  INSTR_W  fetched instruction.
- in_pc4  in  PC_W  PC+4 of the fetched instruction.
- out_valid  out  1  decode-side beat valid.
- out_ready  in  1  decode accepts; low = stall.
- out_instr  out  INSTR_W  held instruction; NOP_INSTR when out_valid=0.
- out_pc4  out  PC_W  held PC+4; 0 when out_valid=0.
- stall_cnt  out  STAT_W  present only with IF_ID_STATS_EN.
- flush_cnt  out  STAT_W  present only with IF_ID_STATS_EN.

Behaviour:
- Handshakes: accept when in_valid && in_ready; transfer out when out_valid && out_ready. in_valid may rise without waiting for in_ready. Data is stable while out_valid && !out_ready.
- Reset (reset_n=0 at edge): main_valid=0, skid_valid=0, out_instr=NOP_INSTR, out_pc4=0, in_ready=1, counters=0. Reset overrides flush and all handshakes.
- Priority: reset > flush > normal.
- Flush: both valid bits go to 0; outputs go to NOP_INSTR/0; in_ready=1 next cycle. A beat accepted on the flush cycle is dropped. An out transfer on the flush cycle still counts as consumed by decode.
- State is (main_valid, skid_valid), named EMPTY (0,0), ONE (1,0), FULL (1,1). State (0,1) is illegal and must be asserted never to occur.
- EMPTY: on accept, load main and go to ONE.
- ONE with out transfer:
  - with accept: main takes new beat, stays ONE (back-to-back).
  - without accept: go to EMPTY.
- ONE, no out transfer:
  - with accept: beat goes to skid, go to FULL, in_ready=0 next cycle.
  - without accept: hold.
- FULL (in_ready=0, no accept possible):
  - on out transfer: skid moves to main, go to ONE, in_ready=1 next cycle.
  - otherwise hold.
- Order is preserved: the main entry always leaves before the skid entry.
- No combinational path from out_ready to in_ready.

Optional Feature:
- Macro IF_ID_STATS_EN.
- Defined:
  - stall_cnt increments every cycle with out_valid && !out_ready.
  - flush_cnt increments every cycle flush=1 and reset_n=1.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: counters and both ports are absent; no other behaviour changes.

Decomposition:
- Package mips_pipe_pkg holds:
  - default widths INSTR_W/PC_W;
  - the NOP_INSTR constant (sll $0,$0,0 = 0);
  - an if_id_beat_t struct {instr, pc4}.
- One natural sub-module, pipe_slot: a single valid+payload register with load/clear. It is instantiated twice, as main and skid.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with in_valid=1 -> out_valid=0, out_instr=0, out_pc4=0, in_ready=1; first beat is accepted only after release.
- Streaming: out_ready=1, feed instr 0x8C010004/pc4 0x4, then 0x20220001/0x8, then one more beat -> each appears on out exactly 1 cycle later, in_ready stays 1.
- Stall into skid: main holds 0xAAAA0001, out_ready=0, present 0xBBBB0002 -> accepted, in_ready=0 next cycle. Raise out_ready -> out shows 0xAAAA0001 then 0xBBBB0002, in_ready returns to 1.
- Flush: in FULL state, pulse flush with in_valid=1 (0xCCCC0003) -> next cycle out_valid=0, out_instr=NOP, in_ready=1, and 0xCCCC0003 never appears.
- Reset mid-operation: FULL state with reset_n=0 and flush=1 simultaneously -> reset values as in the first test; no entry survives.
- IF_ID_STATS_EN defined: 5 stall cycles plus 2 flush cycles -> stall_cnt=5, flush_cnt=2. Force STAT_W=2 with 6 stall cycles -> stall_cnt saturates at 3.
